// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the F/D/E/M/WB pipeline: E-stage forwarding, load-use
// bubbles, branch flushes, and a global freeze while data memory is waiting.
module pipeline_hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             memr_e,
  input  logic [4:0]       rd_m,
  input  logic             regw_m,
  input  logic [4:0]       rd_wb,
  input  logic             regw_wb,
  input  logic             sel,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             pipe_en,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic mem_wait;
  logic run_en;
  logic lu;
  logic bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // M result is newer than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic wm,
                                         input logic [4:0] rdw, input logic ww);
    if (wm && (rdm != 5'd0) && (rdm == rs))      return 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs)) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    mem_wait = mem_req_m && !mem_ready;
    run_en   = (state_q != S_ERR) && !mem_wait;
    lu       = memr_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    bubble   = run_en && !sel && lu;

    pipe_en = !rst && run_en;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(rs1_e, rd_m, regw_m, rd_wb, regw_wb);
      fwd_b = fwd_sel(rs2_e, rd_m, regw_m, rd_wb, regw_wb);
    end
    // Freeze masks everything; the D instruction is discarded on a branch.
    if (pipe_en) begin
      if (sel) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        // wcnt holds the wait cycles already completed; this edge ends one more.
        if (!mem_wait) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RUN;
    endcase
    if (!run_en || bubble) stall_cycles_d = sat_inc(stall_cycles_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_RUN;
      wcnt_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_err      = (state_q == S_ERR);
  assign stall_cycles = stall_cycles_q;

endmodule
